// File: rtl/commit_lockstep_checker.sv
// Lockstep writeback checker: buffers architectural-model commits in a FIFO and
// compares each pipelined-core commit against the oldest entry, latching the first error.
module commit_lockstep_checker #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int XLEN    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     model_valid,
    input  logic [4:0]               model_rd,
    input  logic [XLEN-1:0]          model_data,
    input  logic                     core_valid,
    input  logic [4:0]               core_rd,
    input  logic [XLEN-1:0]          core_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              match_count,
    output logic                     error,
    output logic [2:0]               err_code,
    output logic [4:0]               err_exp_rd,
    output logic [XLEN-1:0]          err_exp_data,
    output logic [4:0]               err_got_rd,
    output logic [XLEN-1:0]          err_got_data,
    output logic [31:0]              err_cycle
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_RUN,
        ST_FAIL
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_DATA    = 3'd1,
        ERR_RD      = 3'd2,
        ERR_UNDER   = 3'd3,
        ERR_OVER    = 3'd4,
        ERR_TIMEOUT = 3'd5
    } err_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [4:0]            r_mem_rd   [DEPTH];
    logic [XLEN-1:0]       r_mem_data [DEPTH];
    logic [PTR_W-1:0]      r_wptr;
    logic [PTR_W-1:0]      r_rptr;
    logic [OCC_W-1:0]      r_occ;
    logic [STALL_W-1:0]    r_stall;
    logic [31:0]           r_match;
    logic [31:0]           r_cycle;

    logic                  r_error;
    err_t                  r_err_code;
    logic [4:0]            r_err_exp_rd;
    logic [XLEN-1:0]       r_err_exp_data;
    logic [4:0]            r_err_got_rd;
    logic [XLEN-1:0]       r_err_got_data;
    logic [31:0]           r_err_cycle;

    logic                  w_model;
    logic                  w_core;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_bypass;
    logic                  w_pop_req;
    logic                  w_cmp;
    logic                  w_stall_hit;
    logic [4:0]            w_head_rd;
    logic [XLEN-1:0]       w_head_data;
    logic [4:0]            w_exp_rd;
    logic [XLEN-1:0]       w_exp_data;

    err_t                  w_err;
    logic [4:0]            w_cap_exp_rd;
    logic [XLEN-1:0]       w_cap_exp_data;
    logic [4:0]            w_cap_got_rd;
    logic [XLEN-1:0]       w_cap_got_data;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_match;

    // Writes to x0 are architecturally invisible, so they never enter the comparison.
    assign w_model     = model_valid && (model_rd != 5'd0);
    assign w_core      = core_valid && (core_rd != 5'd0);
    assign w_empty     = (r_occ == '0);
    assign w_full      = (r_occ == OCC_W'(DEPTH));
    assign w_bypass    = w_empty && w_model && w_core;
    assign w_pop_req   = w_core && !w_empty;
    assign w_cmp       = w_bypass || w_pop_req;
    assign w_head_rd   = r_mem_rd[r_rptr];
    assign w_head_data = r_mem_data[r_rptr];
    assign w_exp_rd    = w_bypass ? model_rd   : w_head_rd;
    assign w_exp_data  = w_bypass ? model_data : w_head_data;
    assign w_stall_hit = !w_empty && !w_pop_req && (r_stall == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_state_next;
    end

    // Error detection in priority order; FIFO/match updates happen only on error-free RUN cycles.
    always_comb begin
        w_state_next   = r_state;
        w_err          = ERR_NONE;
        w_cap_exp_rd   = '0;
        w_cap_exp_data = '0;
        w_cap_got_rd   = '0;
        w_cap_got_data = '0;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_match        = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_cmp && (w_exp_rd != core_rd)) begin
                    w_err          = ERR_RD;
                    w_cap_exp_rd   = w_exp_rd;
                    w_cap_exp_data = w_exp_data;
                    w_cap_got_rd   = core_rd;
                    w_cap_got_data = core_data;
                end else if (w_cmp && (w_exp_data != core_data)) begin
                    w_err          = ERR_DATA;
                    w_cap_exp_rd   = w_exp_rd;
                    w_cap_exp_data = w_exp_data;
                    w_cap_got_rd   = core_rd;
                    w_cap_got_data = core_data;
                end else if (w_core && w_empty && !w_model) begin
                    w_err          = ERR_UNDER;
                    w_cap_got_rd   = core_rd;
                    w_cap_got_data = core_data;
                end else if (w_model && w_full && !w_core) begin
                    w_err          = ERR_OVER;
                    w_cap_exp_rd   = w_head_rd;
                    w_cap_exp_data = w_head_data;
                    w_cap_got_rd   = model_rd;
                    w_cap_got_data = model_data;
                end else if (w_stall_hit) begin
                    w_err          = ERR_TIMEOUT;
                    w_cap_exp_rd   = w_head_rd;
                    w_cap_exp_data = w_head_data;
                end else begin
                    w_push  = w_model && !w_bypass;
                    w_pop   = w_pop_req;
                    w_match = w_cmp;
                end
                if (w_err != ERR_NONE) w_state_next = ST_FAIL;
            end
            default: ;
        endcase
    end

    // NOTE: the entry storage has no reset; pointers and occupancy alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= model_rd;
            r_mem_data[r_wptr] <= model_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_occ   <= '0;
            r_stall <= '0;
            r_match <= '0;
            r_cycle <= '0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            if (r_state == ST_RUN) begin
                if (w_empty || w_pop_req) r_stall <= '0;
                else                      r_stall <= r_stall + STALL_W'(1);
            end
            if (w_match && (r_match != 32'hFFFF_FFFF)) r_match <= r_match + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_error        <= 1'b0;
            r_err_code     <= ERR_NONE;
            r_err_exp_rd   <= '0;
            r_err_exp_data <= '0;
            r_err_got_rd   <= '0;
            r_err_got_data <= '0;
            r_err_cycle    <= '0;
        end else if (w_err != ERR_NONE) begin
            r_error        <= 1'b1;
            r_err_code     <= w_err;
            r_err_exp_rd   <= w_cap_exp_rd;
            r_err_exp_data <= w_cap_exp_data;
            r_err_got_rd   <= w_cap_got_rd;
            r_err_got_data <= w_cap_got_data;
            r_err_cycle    <= r_cycle;
        end
    end

    assign occupancy    = r_occ;
    assign match_count  = r_match;
    assign error        = r_error;
    assign err_code     = r_err_code;
    assign err_exp_rd   = r_err_exp_rd;
    assign err_exp_data = r_err_exp_data;
    assign err_got_rd   = r_err_got_rd;
    assign err_got_data = r_err_got_data;
    assign err_cycle    = r_err_cycle;

endmodule

// File: tb/tb_commit_lockstep_checker.sv
// Directed-vector bench for commit_lockstep_checker: one task per scenario, inline checks.
module tb_commit_lockstep_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        model_valid = 1'b0;
    logic [4:0]  model_rd = '0;
    logic [31:0] model_data = '0;
    logic        core_valid = 1'b0;
    logic [4:0]  core_rd = '0;
    logic [31:0] core_data = '0;
    logic [3:0]  occupancy;
    logic [31:0] match_count;
    logic        error;
    logic [2:0]  err_code;
    logic [4:0]  err_exp_rd;
    logic [31:0] err_exp_data;
    logic [4:0]  err_got_rd;
    logic [31:0] err_got_data;
    logic [31:0] err_cycle;

    int n_pass  = 0;
    int n_total = 0;

    commit_lockstep_checker #(.DEPTH(8), .TIMEOUT(64), .XLEN(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .model_valid  (model_valid),
        .model_rd     (model_rd),
        .model_data   (model_data),
        .core_valid   (core_valid),
        .core_rd      (core_rd),
        .core_data    (core_data),
        .occupancy    (occupancy),
        .match_count  (match_count),
        .error        (error),
        .err_code     (err_code),
        .err_exp_rd   (err_exp_rd),
        .err_exp_data (err_exp_data),
        .err_got_rd   (err_got_rd),
        .err_got_data (err_got_data),
        .err_cycle    (err_cycle)
    );

    always #5 clk = ~clk;

    // Drive one cycle of commits, then sample 1 time unit after the edge.
    task automatic step(input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                        input logic cv, input logic [4:0] crd, input logic [31:0] cd);
        model_valid = mv; model_rd = mrd; model_data = md;
        core_valid  = cv; core_rd  = crd; core_data  = cd;
        @(posedge clk); #1;
        model_valid = 1'b0; core_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        model_valid = 1'b0; core_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        model_valid = 1'b0; core_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (occupancy !== 4'd0)    $display("FAIL reset_occ got %0d exp 0", occupancy); else n_pass++;
        n_total++; if (match_count !== 32'd0) $display("FAIL reset_match got %0d exp 0", match_count); else n_pass++;
        n_total++; if (error !== 1'b0)        $display("FAIL reset_error got %0b exp 0", error); else n_pass++;
        n_total++; if (err_code !== 3'd0)     $display("FAIL reset_code got %0d exp 0", err_code); else n_pass++;
        n_total++; if ({err_exp_rd, err_exp_data, err_got_rd, err_got_data, err_cycle} !== '0)
            $display("FAIL reset_capture got %0h exp 0", {err_exp_rd, err_exp_data, err_got_rd, err_got_data, err_cycle}); else n_pass++;
    endtask

    task automatic test_in_order();
        do_reset();
        step(1, 5, 32'h11, 0, 0, 0);
        step(1, 7, 32'h22, 0, 0, 0);
        step(1, 9, 32'h33, 0, 0, 0);
        n_total++; if (occupancy !== 4'd3) $display("FAIL inorder_fill got %0d exp 3", occupancy); else n_pass++;
        idle(1);
        step(0, 0, 0, 1, 5, 32'h11);
        n_total++; if (match_count !== 32'd1) $display("FAIL inorder_first got %0d exp 1", match_count); else n_pass++;
        step(0, 0, 0, 1, 7, 32'h22);
        step(0, 0, 0, 1, 9, 32'h33);
        n_total++; if (match_count !== 32'd3) $display("FAIL inorder_match got %0d exp 3", match_count); else n_pass++;
        n_total++; if (occupancy !== 4'd0)    $display("FAIL inorder_occ got %0d exp 0", occupancy); else n_pass++;
        n_total++; if (error !== 1'b0)        $display("FAIL inorder_error got %0b exp 0", error); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1, 10, 32'h1234, 0, 0, 0);
        step(1, 11, 32'h5678, 1, 10, 32'h1234);
        n_total++; if (occupancy !== 4'd1) $display("FAIL b2b_occ_mid got %0d exp 1", occupancy); else n_pass++;
        step(0, 0, 0, 1, 11, 32'h5678);
        n_total++; if (match_count !== 32'd2) $display("FAIL b2b_match got %0d exp 2", match_count); else n_pass++;
        n_total++; if (occupancy !== 4'd0)    $display("FAIL b2b_occ got %0d exp 0", occupancy); else n_pass++;
        n_total++; if (error !== 1'b0)        $display("FAIL b2b_error got %0b exp 0", error); else n_pass++;
    endtask

    task automatic test_data_mismatch();
        do_reset();
        step(1, 3, 32'hDEADBEEF, 0, 0, 0);
        idle(1);
        step(0, 0, 0, 1, 3, 32'hDEADBEEE);
        n_total++; if (error !== 1'b1)              $display("FAIL dm_error got %0b exp 1", error); else n_pass++;
        n_total++; if (err_code !== 3'd1)           $display("FAIL dm_code got %0d exp 1", err_code); else n_pass++;
        n_total++; if (err_exp_data !== 32'hDEADBEEF) $display("FAIL dm_exp_data got %h exp deadbeef", err_exp_data); else n_pass++;
        n_total++; if (err_got_data !== 32'hDEADBEEE) $display("FAIL dm_got_data got %h exp deadbeee", err_got_data); else n_pass++;
        n_total++; if (err_exp_rd !== 5'd3 || err_got_rd !== 5'd3)
            $display("FAIL dm_rds got %0d/%0d exp 3/3", err_exp_rd, err_got_rd); else n_pass++;
        n_total++; if (err_cycle !== 32'd2)         $display("FAIL dm_cycle got %0d exp 2", err_cycle); else n_pass++;
        step(1, 5, 32'h1, 0, 0, 0);
        step(0, 0, 0, 1, 5, 32'h1);
        step(0, 0, 0, 1, 6, 32'h2);
        n_total++; if (match_count !== 32'd0) $display("FAIL dm_frozen_match got %0d exp 0", match_count); else n_pass++;
        n_total++; if (err_code !== 3'd1 || err_got_data !== 32'hDEADBEEE || error !== 1'b1)
            $display("FAIL dm_hold got code %0d data %h exp 1 deadbeee", err_code, err_got_data); else n_pass++;
    endtask

    task automatic test_rd_mismatch();
        do_reset();
        step(1, 8, 32'h5, 0, 0, 0);
        step(0, 0, 0, 1, 9, 32'h6);
        n_total++; if (err_code !== 3'd2) $display("FAIL rdm_code got %0d exp 2", err_code); else n_pass++;
        n_total++; if (err_exp_rd !== 5'd8 || err_got_rd !== 5'd9)
            $display("FAIL rdm_rds got %0d/%0d exp 8/9", err_exp_rd, err_got_rd); else n_pass++;
    endtask

    task automatic test_filter_bypass();
        do_reset();
        step(1, 0, 32'h5, 0, 0, 0);
        n_total++; if (occupancy !== 4'd0) $display("FAIL x0_model_occ got %0d exp 0", occupancy); else n_pass++;
        step(0, 0, 0, 1, 0, 32'h7);
        n_total++; if (error !== 1'b0) $display("FAIL x0_core_error got %0b exp 0", error); else n_pass++;
        step(1, 4, 32'hA, 1, 4, 32'hA);
        n_total++; if (match_count !== 32'd1) $display("FAIL bypass_match got %0d exp 1", match_count); else n_pass++;
        n_total++; if (occupancy !== 4'd0)    $display("FAIL bypass_occ got %0d exp 0", occupancy); else n_pass++;
        n_total++; if (error !== 1'b0)        $display("FAIL bypass_error got %0b exp 0", error); else n_pass++;
        step(1, 4, 32'hA, 1, 4, 32'hB);
        n_total++; if (err_code !== 3'd1 || err_exp_data !== 32'hA || err_got_data !== 32'hB)
            $display("FAIL bypass_mm got code %0d exp %h got %h, need 1 a b", err_code, err_exp_data, err_got_data); else n_pass++;
        n_total++; if (occupancy !== 4'd0) $display("FAIL bypass_mm_occ got %0d exp 0", occupancy); else n_pass++;
    endtask

    task automatic test_full_and_async_reset();
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 5'(i + 1), 32'h100 + i, 0, 0, 0);
        n_total++; if (occupancy !== 4'd8) $display("FAIL full_occ got %0d exp 8", occupancy); else n_pass++;
        step(1, 12, 32'h999, 1, 1, 32'h100);
        n_total++; if (occupancy !== 4'd8 || error !== 1'b0)
            $display("FAIL full_pushpop got occ %0d err %0b exp 8 0", occupancy, error); else n_pass++;
        n_total++; if (match_count !== 32'd1) $display("FAIL full_match got %0d exp 1", match_count); else n_pass++;
        step(1, 13, 32'hAAA, 0, 0, 0);
        n_total++; if (error !== 1'b1 || err_code !== 3'd4)
            $display("FAIL ovf_code got err %0b code %0d exp 1 4", error, err_code); else n_pass++;
        n_total++; if (err_exp_rd !== 5'd2 || err_exp_data !== 32'h101)
            $display("FAIL ovf_exp got %0d/%h exp 2/101", err_exp_rd, err_exp_data); else n_pass++;
        n_total++; if (err_got_rd !== 5'd13 || err_got_data !== 32'hAAA)
            $display("FAIL ovf_got got %0d/%h exp 13/aaa", err_got_rd, err_got_data); else n_pass++;
        n_total++; if (occupancy !== 4'd8) $display("FAIL ovf_occ got %0d exp 8", occupancy); else n_pass++;
        // Raise reset between edges and sample before the next rising edge.
        #2 reset = 1'b1;
        #1;
        n_total++; if (error !== 1'b0 || err_code !== 3'd0 || occupancy !== 4'd0)
            $display("FAIL async_reset got err %0b code %0d occ %0d exp 0 0 0", error, err_code, occupancy); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_underflow();
        do_reset();
        step(0, 0, 0, 1, 6, 32'h1);
        n_total++; if (error !== 1'b1 || err_code !== 3'd3)
            $display("FAIL udf_code got err %0b code %0d exp 1 3", error, err_code); else n_pass++;
        n_total++; if (err_exp_rd !== 5'd0 || err_exp_data !== 32'd0)
            $display("FAIL udf_exp got %0d/%h exp 0/0", err_exp_rd, err_exp_data); else n_pass++;
        n_total++; if (err_got_rd !== 5'd6 || err_got_data !== 32'h1)
            $display("FAIL udf_got got %0d/%h exp 6/1", err_got_rd, err_got_data); else n_pass++;
        n_total++; if (err_cycle !== 32'd0) $display("FAIL udf_cycle got %0d exp 0", err_cycle); else n_pass++;
    endtask

    task automatic test_timeout();
        do_reset();
        step(1, 2, 32'h7, 0, 0, 0);
        idle(63);
        n_total++; if (error !== 1'b0) $display("FAIL tmo_early got err %0b exp 0", error); else n_pass++;
        idle(1);
        n_total++; if (error !== 1'b1 || err_code !== 3'd5)
            $display("FAIL tmo_code got err %0b code %0d exp 1 5", error, err_code); else n_pass++;
        n_total++; if (err_exp_rd !== 5'd2 || err_exp_data !== 32'h7 || err_got_rd !== 5'd0 || err_got_data !== 32'd0)
            $display("FAIL tmo_capture got %0d/%h %0d/%h exp 2/7 0/0", err_exp_rd, err_exp_data, err_got_rd, err_got_data); else n_pass++;
        n_total++; if (err_cycle !== 32'd64) $display("FAIL tmo_cycle got %0d exp 64", err_cycle); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_back_to_back();
        test_data_mismatch();
        test_rd_mismatch();
        test_filter_bypass();
        test_full_and_async_reset();
        test_underflow();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
